// File: rtl/amem_spy_port.sv
// Spy-bus initiator for port B of the 1k x 32 A-memory: sequences 16-bit host strobes into RAM cycles.
// Optional: AMEM_SPY_AUTOINC_EN makes every high-half (sel=10) access post-increment the address.
module amem_spy_port #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_strobe,
  input  logic              host_we,
  input  logic [1:0]        host_sel,
  input  logic [15:0]       host_wdata,
  output logic [15:0]       host_rdata,
  output logic              host_ack,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_address,
  output logic [31:0]       ram_data,
  output logic              ram_wren,
  output logic              ram_rden,
  input  logic [31:0]       ram_q
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    WAIT  = 3'd3,
    ACK   = 3'd4
  } state_t;

  localparam logic [1:0] SEL_ADDR = 2'b00;
  localparam logic [1:0] SEL_LO   = 2'b01;
  localparam logic [1:0] SEL_HI   = 2'b10;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   addr_reg;
  logic [15:0]         wbuf_lo;
  logic [31:0]         rbuf;
  logic                accept;

  assign accept = (state == IDLE) && host_strobe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (host_strobe) begin
          if (host_sel == SEL_HI) state_nxt = host_we ? WRITE : READ;
          else                    state_nxt = ACK;
        end
      end
      WRITE:   state_nxt = ACK;
      READ:    state_nxt = WAIT;
      WAIT:    state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes decode straight from the state register so reset drops them asynchronously.
  assign busy        = (state != IDLE);
  assign host_ack    = (state == ACK);
  assign ram_wren    = (state == WRITE);
  assign ram_rden    = (state == READ);
  assign ram_address = addr_reg;

`ifdef AMEM_SPY_AUTOINC_EN
  logic hi_access;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       hi_access <= 1'b0;
    else if (accept) hi_access <= (host_sel == SEL_HI);
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg   <= '0;
      wbuf_lo    <= '0;
      rbuf       <= '0;
      ram_data   <= '0;
      host_rdata <= '0;
    end else begin
      if (accept) begin
        case (host_sel)
          SEL_ADDR: begin
            if (host_we) addr_reg   <= host_wdata[ADDR_W-1:0];
            else         host_rdata <= 16'(addr_reg);
          end
          SEL_LO: begin
            if (host_we) wbuf_lo    <= host_wdata;
            else         host_rdata <= rbuf[15:0];
          end
          SEL_HI: begin
            if (host_we) ram_data <= {host_wdata, wbuf_lo};
          end
          default: host_rdata <= '0;
        endcase
      end
      // Whole word is latched so the low half can be read back later without a RAM cycle.
      if (state == WAIT) begin
        rbuf       <= ram_q;
        host_rdata <= ram_q[31:16];
      end
`ifdef AMEM_SPY_AUTOINC_EN
      if ((state == ACK) && hi_access) addr_reg <= addr_reg + ADDR_W'(1);
`endif
    end
  end

endmodule

// File: tb/tb_amem_spy_port.sv
// Scoreboard bench for amem_spy_port with a behavioural 1k x 32 RAM on port B.
module tb_amem_spy_port;

  localparam int ADDR_W = 10;
`ifdef AMEM_SPY_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              host_strobe;
  logic              host_we;
  logic [1:0]        host_sel;
  logic [15:0]       host_wdata;
  logic [15:0]       host_rdata;
  logic              host_ack;
  logic              busy;
  logic [ADDR_W-1:0] ram_address;
  logic [31:0]       ram_data;
  logic              ram_wren;
  logic              ram_rden;
  logic [31:0]       ram_q;

  amem_spy_port #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .host_strobe (host_strobe),
    .host_we     (host_we),
    .host_sel    (host_sel),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .host_ack    (host_ack),
    .busy        (busy),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_rden    (ram_rden),
    .ram_q       (ram_q)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    if (ram_rden) ram_q <= mem[ram_address];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int wren_cnt = 0;
  int rden_cnt = 0;
  logic [ADDR_W-1:0] last_waddr;
  logic [31:0]       last_wdata;
  logic [15:0]       exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ram_wren) begin
      wren_cnt++;
      last_waddr = ram_address;
      last_wdata = ram_data;
    end
    if (ram_rden) rden_cnt++;
    if (ram_wren && ram_rden) check("wren_rden_excl", 1, 0);
  end

  // One host access: push expected read data, strobe, then measure ack latency and pop/compare.
  task automatic access(input string tag, input logic we, input logic [1:0] sel,
                        input logic [15:0] wd, input int exp_lat,
                        input bit has_rd, input logic [15:0] exp_rd);
    int cyc;
    logic [15:0] e;
    if (has_rd) exp_q.push_back(exp_rd);
    @(negedge clk);
    host_strobe = 1'b1; host_we = we; host_sel = sel; host_wdata = wd;
    @(posedge clk); #1;
    host_strobe = 1'b0;
    cyc = 1;
    while (!host_ack && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_lat"}, cyc, exp_lat);
    if (has_rd) begin
      if (exp_q.size() == 0) check({tag, "_sb_empty"}, 1, 0);
      else begin
        e = exp_q.pop_front();
        check({tag, "_rdata"}, host_rdata, e);
      end
    end
    @(posedge clk); #1;
    check({tag, "_ack_single"}, host_ack, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  int w0, r0, acks;
  logic [ADDR_W-1:0] exp_addr;

  initial begin
    reset = 1'b1; host_strobe = 1'b0; host_we = 1'b0; host_sel = '0; host_wdata = '0;
    ram_q = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", host_rdata, 0);
    check("rst_ack", host_ack, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", ram_address, 0);
    check("rst_data", ram_data, 0);
    check("rst_wren", ram_wren, 0);
    check("rst_rden", ram_rden, 0);
    @(negedge clk); reset = 1'b0;

    // Address register round trip.
    w0 = wren_cnt; r0 = rden_cnt;
    access("addr_wr", 1'b1, 2'b00, 16'h0155, 1, 1'b0, '0);
    access("addr_rd", 1'b0, 2'b00, 16'h0000, 1, 1'b1, 16'h0155);
    check("addr_no_wren", wren_cnt - w0, 0);
    check("addr_no_rden", rden_cnt - r0, 0);

    // RAM write: low half then high half commits the word.
    access("set5", 1'b1, 2'b00, 16'h0005, 1, 1'b0, '0);
    w0 = wren_cnt;
    access("lo_wr", 1'b1, 2'b01, 16'hBEEF, 1, 1'b0, '0);
    access("hi_wr", 1'b1, 2'b10, 16'hDEAD, 2, 1'b0, '0);
    check("wr_pulses", wren_cnt - w0, 1);
    check("wr_addr", last_waddr, 5);
    check("wr_data", last_wdata, 32'hDEADBEEF);
    check("mem5", mem[5], 32'hDEADBEEF);

    // RAM read: high half fetches the word, low half from the buffer.
    access("set5b", 1'b1, 2'b00, 16'h0005, 1, 1'b0, '0);
    r0 = rden_cnt;
    access("hi_rd", 1'b0, 2'b10, 16'h0000, 3, 1'b1, 16'hDEAD);
    check("rd_pulses", rden_cnt - r0, 1);
    r0 = rden_cnt;
    access("lo_rd", 1'b0, 2'b01, 16'h0000, 1, 1'b1, 16'hBEEF);
    check("lo_no_rden", rden_cnt - r0, 0);

    // Strobe during WAIT must be ignored.
    access("set5c", 1'b1, 2'b00, 16'h0005, 1, 1'b0, '0);
    exp_q.push_back(16'hDEAD);
    @(negedge clk);
    host_strobe = 1'b1; host_we = 1'b0; host_sel = 2'b10; host_wdata = '0;
    @(posedge clk); #1; host_strobe = 1'b0;
    check("busy_c1", busy, 1);
    check("rden_c1", ram_rden, 1);
    @(posedge clk); #1;
    host_strobe = 1'b1; host_we = 1'b1; host_sel = 2'b00; host_wdata = 16'h03FF;
    @(posedge clk); #1; host_strobe = 1'b0;
    check("wait_ack_c3", host_ack, 1);
    if (exp_q.size() != 0) check("wait_rdata", host_rdata, exp_q.pop_front());
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (host_ack) acks++;
    end
    check("wait_extra_acks", acks, 0);
    exp_addr = AUTOINC ? 10'd6 : 10'd5;
    access("wait_addr_rd", 1'b0, 2'b00, 16'h0000, 1, 1'b1, 16'(exp_addr));

    // Reserved select: ack with zero data, no state change.
    w0 = wren_cnt;
    access("sel11_wr", 1'b1, 2'b11, 16'h1234, 1, 1'b1, 16'h0000);
    check("sel11_no_wren", wren_cnt - w0, 0);
    access("sel11_addr", 1'b0, 2'b00, 16'h0000, 1, 1'b1, 16'(exp_addr));

    // Address wrap at the top word.
    access("set1023", 1'b1, 2'b00, 16'h03FF, 1, 1'b0, '0);
    access("hi_wr1023", 1'b1, 2'b10, 16'h5A5A, 2, 1'b0, '0);
    exp_addr = AUTOINC ? 10'd0 : 10'd1023;
    access("wrap_addr", 1'b0, 2'b00, 16'h0000, 1, 1'b1, 16'(exp_addr));

    // Reset while waiting on read data.
    access("set5d", 1'b1, 2'b00, 16'h0005, 1, 1'b0, '0);
    @(negedge clk);
    host_strobe = 1'b1; host_we = 1'b0; host_sel = 2'b10;
    @(posedge clk); #1; host_strobe = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("mrst_rden", ram_rden, 0);
    check("mrst_busy", busy, 0);
    check("mrst_ack", host_ack, 0);
    check("mrst_addr", ram_address, 0);
    check("mrst_rdata", host_rdata, 0);
    check("mrst_data", ram_data, 0);
    @(posedge clk); @(negedge clk); reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (host_ack) acks++;
    end
    check("mrst_no_ack", acks, 0);
    access("post_rst_addr", 1'b0, 2'b00, 16'h0000, 1, 1'b1, 16'h0000);
    access("post_rst_lo", 1'b0, 2'b01, 16'h0000, 1, 1'b1, 16'h0000);

    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
